// File: rtl/reg_wb_scoreboard.sv
// Writeback arbiter (ALU vs load) for the single register-file write port, plus a
// pending-write scoreboard that stalls decode on RAW/WAW hazards.
// Build option: define REG_WB_RR_EN for round-robin conflict arbitration (default: mem wins).
module reg_wb_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_en,
    output logic            issue_stall,
    output logic            write_en,
    output logic [4:0]      write_addr,
    output logic [XLEN-1:0] write_value,
    output logic [NREG-1:0] busy_mask
);

    logic            alu_pref_s;
    logic            grant_s;
    logic [4:0]      grant_addr_s;
    logic [XLEN-1:0] grant_data_s;
    logic            write_en_q, write_en_d;
    logic [4:0]      write_addr_q, write_addr_d;
    logic [XLEN-1:0] write_value_q, write_value_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] one_s, set_s, clr_s;

`ifdef REG_WB_RR_EN
    logic both_s;
    logic prio_q, prio_d;

    // Priority pointer next state: the loser of a conflict is preferred at the next one.
    always_comb begin
        both_s = alu_valid & mem_valid;
        if (both_s) begin
            prio_d = mem_ready;
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority pointer register; 0 means mem-preferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign alu_pref_s = prio_q;
`else
    assign alu_pref_s = 1'b0;
`endif

    // Grant selection and winning request mux.
    always_comb begin
        alu_ready = alu_valid & (~mem_valid | alu_pref_s);
        mem_ready = mem_valid & (~alu_valid | ~alu_pref_s);
        grant_s   = alu_ready | mem_ready;
        if (alu_ready) begin
            grant_addr_s = alu_addr;
            grant_data_s = alu_data;
        end else begin
            grant_addr_s = mem_addr;
            grant_data_s = mem_data;
        end
    end

    // Write stage next state; a grant to x0 is consumed without strobing.
    always_comb begin
        write_en_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_value_d = write_value_q;
        if (grant_s) begin
            write_en_d    = (grant_addr_s != 5'd0);
            write_addr_d  = grant_addr_s;
            write_value_d = grant_data_s;
        end else begin
            write_en_d    = 1'b0;
        end
    end

    // Hazard detection against the registered scoreboard only.
    always_comb begin
        issue_stall = issue_valid & ((issue_use_rs1 & busy_q[issue_rs1]) |
                                     (issue_use_rs2 & busy_q[issue_rs2]) |
                                     (issue_rd_en   & busy_q[issue_rd]));
    end

    // Scoreboard next state; clear overrides set and bit 0 is never pending.
    always_comb begin
        one_s = {{(NREG-1){1'b0}}, 1'b1};
        if (issue_valid & ~issue_stall & issue_rd_en & (issue_rd != 5'd0)) begin
            set_s = one_s << issue_rd;
        end else begin
            set_s = {NREG{1'b0}};
        end
        if (grant_s & (grant_addr_s != 5'd0)) begin
            clr_s = one_s << grant_addr_s;
        end else begin
            clr_s = {NREG{1'b0}};
        end
        busy_d = (busy_q | set_s) & ~clr_s & ~one_s;
    end

    // State registers; reset discards pending bits and any grant of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_en_q    <= 1'b0;
            write_addr_q  <= 5'd0;
            write_value_q <= {XLEN{1'b0}};
            busy_q        <= {NREG{1'b0}};
        end else begin
            write_en_q    <= write_en_d;
            write_addr_q  <= write_addr_d;
            write_value_q <= write_value_d;
            busy_q        <= busy_d;
        end
    end

    assign write_en    = write_en_q;
    assign write_addr  = write_addr_q;
    assign write_value = write_value_q;
    assign busy_mask   = busy_q;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Randomized + directed bench for reg_wb_scoreboard against a behavioural register-state model.
module tb_reg_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_rd_en, issue_stall;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_value;
    logic [31:0] busy_mask;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference state: pending flag per architectural register and the visible write port.
    bit          pend[32];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wv;
    bit          alu_turn;   // RR only: ALU wins the next conflict
    bit          g_alu, g_mem;

    reg_wb_scoreboard #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_stall(issue_stall),
        .write_en(write_en), .write_addr(write_addr), .write_value(write_value),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = 32'd0;
        for (int i = 1; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    function automatic bit model_stall();
        if (!issue_valid) return 1'b0;
        return (issue_use_rs1 && pend[issue_rs1]) || (issue_use_rs2 && pend[issue_rs2]) ||
               (issue_rd_en && pend[issue_rd]);
    endfunction

    task automatic idle();
        reset = 1'b0;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_rd = 5'd0; issue_rd_en = 1'b0;
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registers.
    task automatic step();
        bit          stall_e;
        logic [4:0]  ga;
        logic [31:0] gd;
        #1;
        stall_e = model_stall();
        if (alu_valid && mem_valid) begin
`ifdef REG_WB_RR_EN
            g_alu = alu_turn;
`else
            g_alu = 1'b0;
`endif
            g_mem = !g_alu;
        end else begin
            g_alu = alu_valid;
            g_mem = mem_valid;
        end
        check_eq("alu_ready", alu_ready, g_alu);
        check_eq("mem_ready", mem_ready, g_mem);
        check_eq("issue_stall", issue_stall, stall_e);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) pend[i] = 1'b0;
            m_we = 1'b0; m_wa = 5'd0; m_wv = 32'd0; alu_turn = 1'b0;
        end else begin
            if (issue_valid && !stall_e && issue_rd_en && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
            if (g_alu || g_mem) begin
                ga = g_alu ? alu_addr : mem_addr;
                gd = g_alu ? alu_data : mem_data;
                m_wa = ga; m_wv = gd; m_we = (ga != 5'd0);
                if (ga != 5'd0) pend[ga] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (alu_valid && mem_valid) alu_turn = g_mem;
        end
        #1;
        check_eq("write_en", write_en, m_we);
        check_eq("write_addr", write_addr, m_wa);
        check_eq("write_value", write_value, m_wv);
        check_eq("busy_mask", busy_mask, pend_vec());
        @(negedge clk);
    endtask

    initial begin
        bit ap, mp;
        logic [3:0] pat;
        idle();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        m_we = 1'b0; m_wa = 5'd0; m_wv = 32'd0; alu_turn = 1'b0;
        @(negedge clk);
        reset = 1'b1; step(); reset = 1'b0;
        check_eq("rst_write_en", write_en, 1'b0);
        check_eq("rst_busy", busy_mask, 32'd0);

        // Conflict: four cycles of both sources valid
`ifdef REG_WB_RR_EN
        pat = 4'b1010;
`else
        pat = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            idle(); alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
            mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
            #1 check_eq($sformatf("conflict_alu%0d", i), alu_ready, pat[i]);
            step();
        end

        // ALU only write to x5
        idle(); issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_en = 1'b1; step();
        check_eq("alu_busy5_set", busy_mask[5], 1'b1);
        idle(); alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234; step();
        check_eq("alu_wv", write_value, 32'h1234);
        check_eq("alu_busy5_clr", busy_mask[5], 1'b0);

        // RAW on x3 resolved by a load writeback
        idle(); issue_valid = 1'b1; issue_rd = 5'd3; issue_rd_en = 1'b1; step();
        idle(); issue_valid = 1'b1; issue_rs1 = 5'd3; issue_use_rs1 = 1'b1; step();
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hCAFE; step();
        mem_valid = 1'b0;
        #1 check_eq("raw_released", issue_stall, 1'b0);
        step();

        // x0 writeback and rd=0 issue
        idle(); alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF; step();
        check_eq("x0_we", write_en, 1'b0);
        idle(); issue_valid = 1'b1; issue_rd = 5'd0; issue_rd_en = 1'b1; step();
        check_eq("x0_busy", busy_mask, 32'd0);

        // WAW on x7
        idle(); issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_en = 1'b1; step();
        #1 check_eq("waw_stall", issue_stall, 1'b1);
        step();
        check_eq("waw_busy", busy_mask, 32'h80);

        // Reset while x3/x5/x7 pending and a grant is presented
        idle(); issue_valid = 1'b1; issue_rd_en = 1'b1;
        issue_rd = 5'd3; step();
        issue_rd = 5'd5; step();
        check_eq("midrst_pre", busy_mask, 32'hA8);
        idle(); reset = 1'b1; alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h5555; step();
        check_eq("midrst_busy", busy_mask, 32'd0);
        check_eq("midrst_we", write_en, 1'b0);
        check_eq("midrst_wv", write_value, 32'd0);
        idle(); alu_valid = 1'b1; alu_addr = 5'd1; mem_valid = 1'b1; mem_addr = 5'd2;
        #1 check_eq("midrst_mem_first", mem_ready, 1'b1);
        step();

        // Random traffic; sources hold their request until the model grants it
        idle(); ap = 1'b0; mp = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(99) == 0);
            if (!ap && $urandom_range(1)) begin
                ap = 1'b1; alu_addr = 5'($urandom_range(7)); alu_data = $urandom;
            end
            if (!mp && $urandom_range(1)) begin
                mp = 1'b1; mem_addr = 5'($urandom_range(7)); mem_data = $urandom;
            end
            alu_valid = ap; mem_valid = mp;
            issue_valid = 1'($urandom_range(1));
            issue_rs1 = 5'($urandom_range(7)); issue_use_rs1 = 1'($urandom_range(1));
            issue_rs2 = 5'($urandom_range(7)); issue_use_rs2 = 1'($urandom_range(1));
            issue_rd = 5'($urandom_range(7)); issue_rd_en = 1'($urandom_range(1));
            step();
            if (reset) begin
                ap = 1'b0; mp = 1'b0;
            end else begin
                if (g_alu) ap = 1'b0;
                if (g_mem) mp = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
